// File: rtl/data_memory.sv
// Word-addressed single-port data RAM for the memory stage.
// Registered, write-first read; async reset clears output and array.
module data_memory #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 2048
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [ADDR_WIDTH-1:0] Data_address,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] Data_out
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;

   // Full-width compare so high addresses never alias onto low words
   assign in_range = (Data_address < ADDR_WIDTH'(DEPTH));
   assign idx      = Data_address[IDX_W-1:0];

   always_comb begin
      data_d = '0;
      if (in_range) begin
         data_d = we ? Data_in : mem_q[idx];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         data_q <= '0;
      end else begin
         if ((we == 1'b1) && (in_range == 1'b1)) begin
            mem_q[idx] <= Data_in;
         end
         data_q <= data_d;
      end
   end

   assign Data_out = data_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: driver queues expected read data,
// monitor pops and compares after each edge or on an async reset check.
module tb_data_memory;

   logic        Clk;
   logic        Reset_n;
   logic [31:0] Data_address;
   logic [31:0] Data_in;
   logic        we;
   logic [31:0] Data_out;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   event chk_ev;

   data_memory #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .DEPTH(2048)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .Data_address(Data_address),
      .Data_in(Data_in),
      .we(we),
      .Data_out(Data_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Monitor: one expectation consumed per edge (or per async check)
   initial begin
      forever begin
         @(posedge Clk or chk_ev);
         #1;
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (Data_out !== e.exp) begin
               bad++;
               $display("FAIL %s: got=%h want=%h t=%0t",
                        e.name, Data_out, e.exp, $time);
            end
         end
      end
   end

   task automatic acc(input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [31:0] exp,
                      input string name);
      @(negedge Clk);
      Data_address = a;
      Data_in      = d;
      we           = w;
      q.push_back('{name: name, exp: exp});
   endtask

   initial begin
      Reset_n      = 1'b0;
      Data_address = '0;
      Data_in      = '0;
      we           = 1'b0;

      #3;
      q.push_back('{name: "rst_init", exp: 32'h0});
      ->chk_ev;
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

      acc(1024, 32'hFFFF_FFFF, 1'b0, 32'h0, "we0_1024_a");
      acc(1024, 32'hFFFF_FFFF, 1'b0, 32'h0, "we0_1024_b");
      acc(1524, 32'hFFFF_FFFF, 1'b0, 32'h0, "we0_1524");
      acc(1024, 32'h0000_AAAA, 1'b1, 32'h0000_AAAA, "wr_first");
      acc(1024, 32'h0000_5555, 1'b0, 32'h0000_AAAA, "hold_a");
      acc(1024, 32'h0000_5555, 1'b0, 32'h0000_AAAA, "hold_b");
      acc(1524, 32'h0, 1'b0, 32'h0, "rd_1524");

      for (int i = 0; i < 50; i++)
         acc(1024 + i, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, "blk_wr");
      for (int i = 0; i < 50; i++)
         acc(1024 + i, 32'h0, 1'b0, 32'hFFFF_FFFF, "blk_rd");
      acc(1074, 32'h0, 1'b0, 32'h0, "blk_end");

      acc(0, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, "wr_0");
      acc(2048, 32'h1234_5678, 1'b1, 32'h0, "oor_2048");
      acc(0, 32'h0, 1'b0, 32'h5A5A_5A5A, "no_alias_0");
      acc(3072, 32'h1111_1111, 1'b1, 32'h0, "oor_3072");
      acc(32'h8000_0400, 32'h2222_2222, 1'b1, 32'h0, "oor_high");
      acc(1024, 32'h0, 1'b0, 32'hFFFF_FFFF, "no_alias_1024");
      acc(2047, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, "wr_top");
      acc(2047, 32'h0, 1'b0, 32'hCAFE_0001, "rd_top");
      acc(2046, 32'h0, 1'b0, 32'h0, "rd_top_m1");

      @(negedge Clk);
      Data_address = 'x;
      Data_in      = 32'hDEAD_BEEF;
      we           = 1'b0;
      acc(1050, 32'h0, 1'b0, 32'hFFFF_FFFF, "x_addr_safe");
      acc(0, 32'h0, 1'b0, 32'h5A5A_5A5A, "x_addr_safe0");

      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      q.push_back('{name: "rst_async", exp: 32'h0});
      ->chk_ev;

      @(negedge Clk);
      Data_address = 1024;
      Data_in      = 32'h0000_1234;
      we           = 1'b1;
      q.push_back('{name: "rst_hold", exp: 32'h0});
      @(negedge Clk);
      we = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;

      acc(1024, 32'h0, 1'b0, 32'h0, "post_rst_1024");
      acc(1050, 32'h0, 1'b0, 32'h0, "post_rst_1050");
      acc(0, 32'h0, 1'b0, 32'h0, "post_rst_0");
      acc(2047, 32'h0, 1'b0, 32'h0, "post_rst_2047");

      repeat (5) @(posedge Clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
